wb_stage: RTL
=============

# wb_stage

Write-back stage of the five-stage MIPS pipeline. It sits directly downstream of the MEM/WB pipeline register, consumes its `wr_*` outputs and drives the GPR file write port. It owns the architectural HI/LO registers and the CP0 register subset (Count, Compare, Status, Cause, EPC). It raises the pipeline redirect for SYSCALL and ERET, and generates the timer interrupt.

## Interface
- `EXC_VECTOR`, 32'h0000_0380, redirect target for SYSCALL.
- `Clk` in 1: system clock; all state updates on rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: WB slot holds a real instruction; 0 = bubble, no side effects.
- `wr_dout` in 32: load data.
- `wr_alu_result` in 32: ALU result.
- `wr_Rw` in 5: destination GPR.
- `wr_RegWr` in 1: GPR write request.
- `wr_MemtoReg` in 1: select load data.
- `wr_busA` in 32: rs value, for MTHI/MTLO.
- `wr_mul_result` in 64: multiplier product, {hi,lo}.
- `wr_regToMul` in 2: 00 none, 01 HI<=busA, 10 LO<=busA, 11 {HI,LO}<=mul_result.
- `wr_mulToReg` in 1: GPR data comes from HI/LO.
- `wr_mulRead` in 1: 1 = HI, 0 = LO.
- `wr_cs` in 5: CP0 register number.
- `wr_sel` in 3: CP0 select.
- `wr_busB` in 32: rt value, for MTC0.
- `wr_cp0Op` in 3: 000 none, 001 MFC0, 010 MTC0, 011 SYSCALL, 100 ERET, others = none.
- `wr_PC` in 30: word PC of the WB instruction.
- `rf_wen` out 1: GPR write enable.
- `rf_waddr` out 5: GPR write address.
- `rf_wdata` out 32: GPR write data.
- `redirect` out 1: flush pipeline, fetch from `redirect_pc`.
- `redirect_pc` out 32: redirect target.
- `timer_int` out 1: timer interrupt request.
- `cp0_status` out 32: current Status.
- `cp0_epc` out 32: current EPC.

## Operation
- Combinational write port:
  - `rf_wen` = wr_valid & wr_RegWr & (wr_Rw≠0).
  - `rf_waddr` = wr_Rw.
  - `rf_wdata` priority:
    - MFC0 → CP0 read data.
    - else mulToReg → HI or LO.
    - else MemtoReg → dout.
    - else alu_result.
- Reads return pre-edge register values; no same-cycle bypass of writes.
- CP0 map, sel must be 0:
  - 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
  - Any other cs/sel reads 0 and ignores writes.
- MTC0 write masks:
  - Count, Compare, EPC: full 32 bits.
  - Status: mask 32'h0000_FF03 (IM[15:8], EXL[1], IE[0]).
  - Cause: bits [9:8] only.
- HI/LO update per `wr_regToMul` when wr_valid.
- SYSCALL (wr_valid):
  - EPC <= {wr_PC,2'b00}; Cause[6:2] <= 5'd8; Status[1] <= 1.
  - `redirect`=1, `redirect_pc`=EXC_VECTOR.
- ERET (wr_valid): Status[1] <= 0; `redirect`=1, `redirect_pc`=EPC (pre-edge value).
- No redirect in any other case; `redirect_pc` = 0 when `redirect`=0.
- Timer:
  - Count increments by 1 every cycle, wrapping 32'hFFFF_FFFF→0.
  - Cause[15] set when Count==Compare and Compare≠0.
  - Any MTC0 to Compare clears Cause[15].
  - `timer_int` = Cause[15] & Status[15] & Status[0] & ~Status[1], combinational from registers.
- wr_valid=0: no HI/LO or CP0 writes; Count still counts; `rf_wen`=0; `redirect`=0.

## Timing
- Reset: HI, LO, Count, Compare, Status, Cause, EPC all 0.
- With all registers 0, `timer_int`=0, `cp0_status`=0 and `cp0_epc`=0.
- `rf_*` and `redirect` are combinational from inputs, zero latency.
- State updates land at the next rising edge and are visible to the following WB instruction.
- Count write vs. increment in the same cycle: written value wins, no +1.
- Compare write vs. match in the same cycle: write wins, Cause[15] cleared.
- Compare match vs. Cause MTC0 in the same cycle: bit 15 set, bits [9:8] written.
- Reset asserted mid-operation clears all state immediately; pending writes are lost.

## Test plan
- Reset, then wr_valid=1, RegWr=1, Rw=5, MemtoReg=1, dout=32'hDEAD_BEEF → rf_wen=1, rf_waddr=5, rf_wdata=32'hDEAD_BEEF. Same with Rw=0 → rf_wen=0.
- regToMul=11, mul_result=64'h1234_5678_9ABC_DEF0; next cycle mulToReg=1 with mulRead=1 → 32'h1234_5678, then mulRead=0 → 32'h9ABC_DEF0.
- MTC0 cs=12, busB=32'hFFFF_FFFF; then MFC0 cs=12 → rf_wdata=32'h0000_FF03. MFC0 cs=12, sel=1 → rf_wdata=0.
- SYSCALL, wr_PC=30'h0000_1000 → redirect=1, redirect_pc=32'h380. Next cycle: EPC=32'h4000, Cause[6:2]=8, Status[1]=1. ERET → redirect_pc=32'h4000, then Status[1]=0.
- Timer: Status=32'h0000_8001, Compare=20, Count=0 → Cause[15] and timer_int=1 at the edge after Count==20. MTC0 to Compare → timer_int=0 next cycle.
- wr_valid=0 with SYSCALL and regToMul=11 → redirect=0, rf_wen=0, HI/LO/EPC unchanged, Count advances by 1.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage of the five-stage MIPS pipeline: drives the GPR write port,
// owns HI/LO and the CP0 subset (Count/Compare/Status/Cause/EPC), raises
// SYSCALL/ERET redirects and generates the timer interrupt.
module wb_stage #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0380
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        wr_valid,
  input  logic [31:0] wr_dout,
  input  logic [31:0] wr_alu_result,
  input  logic [4:0]  wr_Rw,
  input  logic        wr_RegWr,
  input  logic        wr_MemtoReg,
  input  logic [31:0] wr_busA,
  input  logic [63:0] wr_mul_result,
  input  logic [1:0]  wr_regToMul,
  input  logic        wr_mulToReg,
  input  logic        wr_mulRead,
  input  logic [4:0]  wr_cs,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_busB,
  input  logic [2:0]  wr_cp0Op,
  input  logic [29:0] wr_PC,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        timer_int,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_epc
);

  typedef enum logic [2:0] {
    CP0_NONE    = 3'b000,
    CP0_MFC0    = 3'b001,
    CP0_MTC0    = 3'b010,
    CP0_SYSCALL = 3'b011,
    CP0_ERET    = 3'b100
  } cp0_op_e;

  typedef enum logic [1:0] {
    MUL_NONE  = 2'b00,
    MUL_HI    = 2'b01,
    MUL_LO    = 2'b10,
    MUL_PROD  = 2'b11
  } mul_wr_e;

  localparam logic [4:0]  CS_COUNT   = 5'd9;
  localparam logic [4:0]  CS_COMPARE = 5'd11;
  localparam logic [4:0]  CS_STATUS  = 5'd12;
  localparam logic [4:0]  CS_CAUSE   = 5'd13;
  localparam logic [4:0]  CS_EPC     = 5'd14;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [4:0]  EXC_SYSCALL  = 5'd8;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_IM7 = 15;
  localparam int CAUSE_TI   = 15;

  // Architectural state.
  logic [31:0] hi_q, lo_q;
  logic [31:0] count_q, compare_q, status_q, cause_q, epc_q;

  logic [31:0] hi_d, lo_d;
  logic [31:0] count_d, compare_d, status_d, cause_d, epc_d;

  // Decoded instruction attributes.
  logic        is_mfc0;
  logic        is_mtc0;
  logic        is_syscall;
  logic        is_eret;
  logic        cp0_sel_ok;
  logic [31:0] cp0_rdata;
  logic [31:0] muldiv_rdata;
  logic        timer_match;

  assign is_mfc0    = (wr_cp0Op == CP0_MFC0);
  assign is_mtc0    = wr_valid && (wr_cp0Op == CP0_MTC0);
  assign is_syscall = wr_valid && (wr_cp0Op == CP0_SYSCALL);
  assign is_eret    = wr_valid && (wr_cp0Op == CP0_ERET);
  assign cp0_sel_ok = (wr_sel == 3'd0);

  assign timer_match = (count_q == compare_q) && (compare_q != 32'd0);

  // CP0 read mux; unmapped cs or non-zero sel reads as zero.
  always_comb begin
    cp0_rdata = 32'd0;
    if (cp0_sel_ok) begin
      case (wr_cs)
        CS_COUNT:   cp0_rdata = count_q;
        CS_COMPARE: cp0_rdata = compare_q;
        CS_STATUS:  cp0_rdata = status_q;
        CS_CAUSE:   cp0_rdata = cause_q;
        CS_EPC:     cp0_rdata = epc_q;
        default:    cp0_rdata = 32'd0;
      endcase
    end
  end

  assign muldiv_rdata = wr_mulRead ? hi_q : lo_q;

  // GPR write port, purely combinational from the WB slot.
  always_comb begin
    rf_wen   = wr_valid && wr_RegWr && (wr_Rw != 5'd0);
    rf_waddr = wr_Rw;
    if (is_mfc0) begin
      rf_wdata = cp0_rdata;
    end else if (wr_mulToReg) begin
      rf_wdata = muldiv_rdata;
    end else if (wr_MemtoReg) begin
      rf_wdata = wr_dout;
    end else begin
      rf_wdata = wr_alu_result;
    end
  end

  // ERET returns to the EPC held before this edge.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    if (is_syscall) begin
      redirect    = 1'b1;
      redirect_pc = EXC_VECTOR;
    end else if (is_eret) begin
      redirect    = 1'b1;
      redirect_pc = epc_q;
    end
  end

  // HI/LO next state.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wr_valid) begin
      case (mul_wr_e'(wr_regToMul))
        MUL_HI:   hi_d = wr_busA;
        MUL_LO:   lo_d = wr_busA;
        MUL_PROD: {hi_d, lo_d} = wr_mul_result;
        default:  ;
      endcase
    end
  end

  // CP0 next state. Later assignments deliberately override earlier ones:
  // an MTC0 to Count beats the increment, an MTC0 to Compare beats a match.
  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;

    if (timer_match) begin
      cause_d[CAUSE_TI] = 1'b1;
    end

    if (is_mtc0 && cp0_sel_ok) begin
      case (wr_cs)
        CS_COUNT:   count_d = wr_busB;
        CS_COMPARE: begin
          compare_d         = wr_busB;
          cause_d[CAUSE_TI] = 1'b0;
        end
        CS_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (wr_busB & STATUS_WMASK);
        CS_CAUSE:   cause_d  = (cause_d & ~CAUSE_WMASK) | (wr_busB & CAUSE_WMASK);
        CS_EPC:     epc_d    = wr_busB;
        default:    ;
      endcase
    end

    if (is_syscall) begin
      epc_d                = {wr_PC, 2'b00};
      cause_d[6:2]         = EXC_SYSCALL;
      status_d[STATUS_EXL] = 1'b1;
    end

    if (is_eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= 32'd0;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
    end
  end

  assign timer_int  = cause_q[CAUSE_TI] & status_q[STATUS_IM7] &
                      status_q[STATUS_IE] & ~status_q[STATUS_EXL];
  assign cp0_status = status_q;
  assign cp0_epc    = epc_q;

endmodule
